// File: rtl/dma_cmd_queue.sv
// dma_cmd_queue: DEPTH-entry DMA descriptor FIFO with a single-command
// dispatcher towards the AHB-Lite master, plus flush, occupancy,
// completion counting and sticky error flags.
module dma_cmd_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LEN_W  = 6,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                     HCLK,
   input  logic                     HRESET,
   input  logic                     SystemStart,
   input  logic                     Master_Done,
   input  logic                     Flush,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [ADDR_W-1:0]        cmd_addr,
   input  logic [LEN_W-1:0]         cmd_len,
   output logic                     NewCommandOn,
   output logic [ADDR_W-1:0]        o_DMA_ADDR,
   output logic [LEN_W-1:0]         o_BUFFER_LENGTH,
   output logic [$clog2(DEPTH):0]   o_cmd_count,
   output logic [CNT_W-1:0]         o_done_cnt,
   output logic                     o_overflow,
   output logic                     o_len_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned QCW   = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
   } desc_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t            state;
   desc_t             mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push;
   logic              pop;
   desc_t             head;

   // Queue has room while the registered occupancy is below DEPTH
   assign cmd_ready = (o_cmd_count < QCW'(DEPTH));

   // Accepted push: room, non-zero length, and no flush this cycle
   assign push = cmd_valid && cmd_ready && (cmd_len != '0) && !Flush;

   // Dispatch decision uses the registered count, so there is no bypass
   assign pop  = (state == IDLE) && SystemStart && (o_cmd_count != '0) && !Flush;

   assign head = mem[rd_ptr];

   // Descriptor storage; contents are don't-care until written
   always_ff @(posedge HCLK) begin
      if (push) begin
         mem[wr_ptr] <= desc_t'{addr: cmd_addr, len: cmd_len};
      end
   end

   // FIFO pointers, occupancy and sticky error flags
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         o_cmd_count <= '0;
         o_overflow  <= 1'b0;
         o_len_err   <= 1'b0;
      end else if (Flush) begin
         // Flush discards queued entries and any push in the same cycle
         rd_ptr      <= wr_ptr;
         o_cmd_count <= '0;
         o_overflow  <= 1'b0;
         o_len_err   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            o_cmd_count <= o_cmd_count + QCW'(1);
         end else if (pop && !push) begin
            o_cmd_count <= o_cmd_count - QCW'(1);
         end
         if (cmd_valid && !cmd_ready) begin
            o_overflow <= 1'b1;
         end
         if (cmd_valid && (cmd_len == '0)) begin
            o_len_err <= 1'b1;
         end
      end
   end

   // Dispatcher: present one descriptor until Master_Done, then count it
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state           <= IDLE;
         NewCommandOn    <= 1'b0;
         o_DMA_ADDR      <= '0;
         o_BUFFER_LENGTH <= '0;
         o_done_cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  o_DMA_ADDR      <= head.addr;
                  o_BUFFER_LENGTH <= head.len;
                  NewCommandOn    <= 1'b1;
                  state           <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (Master_Done) begin
                  NewCommandOn <= 1'b0;
                  o_done_cnt   <= o_done_cnt + CNT_W'(1);
                  state        <= IDLE;
               end
            end
            default: begin
               state        <= IDLE;
               NewCommandOn <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_cmd_queue.sv
// Directed self-checking bench for dma_cmd_queue (DEPTH=4 defaults).
module tb_dma_cmd_queue;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        SystemStart;
   logic        Master_Done;
   logic        Flush;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic [5:0]  cmd_len;
   logic        NewCommandOn;
   logic [31:0] o_DMA_ADDR;
   logic [5:0]  o_BUFFER_LENGTH;
   logic [2:0]  o_cmd_count;
   logic [15:0] o_done_cnt;
   logic        o_overflow;
   logic        o_len_err;

   int n_assert = 0;
   int n_fail   = 0;

   dma_cmd_queue dut (
      .HCLK(HCLK), .HRESET(HRESET), .SystemStart(SystemStart),
      .Master_Done(Master_Done), .Flush(Flush), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .NewCommandOn(NewCommandOn), .o_DMA_ADDR(o_DMA_ADDR),
      .o_BUFFER_LENGTH(o_BUFFER_LENGTH), .o_cmd_count(o_cmd_count),
      .o_done_cnt(o_done_cnt), .o_overflow(o_overflow), .o_len_err(o_len_err)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [5:0] l);
      cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
      step();
      cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
   endtask

   task automatic done_pulse();
      Master_Done = 1'b1;
      step();
      Master_Done = 1'b0;
   endtask

   task automatic flush_pulse();
      Flush = 1'b1;
      step();
      Flush = 1'b0;
   endtask

   function automatic logic [31:0] e_addr(input int k);
      return 32'h4000_0000 + 32'(k) * 32'h100;
   endfunction

   function automatic logic [5:0] e_len(input int k);
      return 6'(k + 1);
   endfunction

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   logic [31:0] t1_addr [3];
   logic [5:0]  t1_len  [3];

   initial begin
      int next_push;
      int exp_cnt;
      logic was_full;

      t1_addr = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
      t1_len  = '{6'd8, 6'd16, 6'd32};

      HRESET = 1'b1; SystemStart = 1'b0; Master_Done = 1'b0; Flush = 1'b0;
      cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
      repeat (3) step();
      HRESET = 1'b0;
      step();

      // Reset state
      chk("rst_nco", NewCommandOn, 0);
      chk("rst_addr", o_DMA_ADDR, 0);
      chk("rst_len", o_BUFFER_LENGTH, 0);
      chk("rst_count", o_cmd_count, 0);
      chk("rst_done", o_done_cnt, 0);
      chk("rst_ovf", o_overflow, 0);
      chk("rst_lerr", o_len_err, 0);
      chk("rst_ready", cmd_ready, 1);

      // Three descriptors dispatched in order
      for (int i = 0; i < 3; i++) push(t1_addr[i], t1_len[i]);
      chk("t1_count3", o_cmd_count, 3);
      chk("t1_nco_idle", NewCommandOn, 0);
      SystemStart = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         chk("t1_nco_on", NewCommandOn, 1);
         chk("t1_addr", o_DMA_ADDR, t1_addr[i]);
         chk("t1_len", o_BUFFER_LENGTH, t1_len[i]);
         chk("t1_count", o_cmd_count, 64'(2 - i));
         repeat (3) step();
         chk("t1_nco_hold", NewCommandOn, 1);
         done_pulse();
         chk("t1_nco_off", NewCommandOn, 0);
         chk("t1_done", o_done_cnt, 64'(i + 1));
         chk("t1_addr_hold", o_DMA_ADDR, t1_addr[i]);
         step();
      end
      chk("t1_nco_end", NewCommandOn, 0);
      chk("t1_done3", o_done_cnt, 3);
      chk("t1_count0", o_cmd_count, 0);
      SystemStart = 1'b0;

      // Overflow: five pushes into a four-deep queue, then flush
      for (int i = 0; i < 4; i++) push(32'h5000_0000 + 32'(i), 6'd4);
      chk("t2_count4", o_cmd_count, 4);
      chk("t2_ready0", cmd_ready, 0);
      chk("t2_ovf0", o_overflow, 0);
      push(32'h5000_0004, 6'd4);
      chk("t2_ovf1", o_overflow, 1);
      chk("t2_count_still4", o_cmd_count, 4);
      flush_pulse();
      chk("t2_flush_count", o_cmd_count, 0);
      chk("t2_flush_ovf", o_overflow, 0);
      chk("t2_flush_ready", cmd_ready, 1);

      // Zero-length push is dropped and flagged
      push(32'h6000_0000, 6'd5);
      chk("t3_count1", o_cmd_count, 1);
      push(32'h6000_0100, 6'd0);
      chk("t3_lerr", o_len_err, 1);
      chk("t3_count_unch", o_cmd_count, 1);
      flush_pulse();
      chk("t3_flush_lerr", o_len_err, 0);
      chk("t3_flush_count", o_cmd_count, 0);

      // Full queue with dispatch, rejected concurrent pushes, wrap order
      for (int k = 0; k < 4; k++) push(e_addr(k), e_len(k));
      chk("t4_full", o_cmd_count, 4);
      SystemStart = 1'b1;
      cmd_valid = 1'b1; cmd_addr = 32'hDEAD_0000; cmd_len = 6'd9;
      step();
      cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
      chk("t4_nco0", NewCommandOn, 1);
      chk("t4_addr0", o_DMA_ADDR, e_addr(0));
      chk("t4_count3", o_cmd_count, 3);
      chk("t4_ovf", o_overflow, 1);
      next_push = 4;
      exp_cnt = 3;
      for (int k = 0; k < 12; k++) begin
         if (next_push < 12) begin
            push(e_addr(next_push), e_len(next_push));
            next_push++;
            exp_cnt++;
            chk("t4_count_push", o_cmd_count, 64'(exp_cnt));
         end
         done_pulse();
         chk("t4_nco_off", NewCommandOn, 0);
         chk("t4_done", o_done_cnt, 64'(4 + k));
         if (k < 11) begin
            was_full = (exp_cnt == 4);
            if (was_full) begin
               cmd_valid = 1'b1; cmd_addr = 32'hDEAD_0000 + 32'(k); cmd_len = 6'd7;
            end
            step();
            cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
            exp_cnt--;
            chk("t4_nco_on", NewCommandOn, 1);
            chk("t4_addr", o_DMA_ADDR, e_addr(k + 1));
            chk("t4_len", o_BUFFER_LENGTH, e_len(k + 1));
            chk("t4_count_pop", o_cmd_count, 64'(exp_cnt));
         end
      end
      step();
      chk("t4_idle_end", NewCommandOn, 0);
      chk("t4_done15", o_done_cnt, 15);
      SystemStart = 1'b0;
      flush_pulse();

      // Flush while a command is active with two entries queued
      push(32'h7000_0000, 6'd10);
      push(32'h7000_0100, 6'd11);
      push(32'h7000_0200, 6'd12);
      SystemStart = 1'b1;
      step();
      chk("t5_nco", NewCommandOn, 1);
      chk("t5_count2", o_cmd_count, 2);
      flush_pulse();
      chk("t5_flush_count", o_cmd_count, 0);
      chk("t5_flush_nco", NewCommandOn, 1);
      chk("t5_flush_addr", o_DMA_ADDR, 32'h7000_0000);
      chk("t5_flush_len", o_BUFFER_LENGTH, 10);
      done_pulse();
      chk("t5_done16", o_done_cnt, 16);
      repeat (3) step();
      chk("t5_no_dispatch", NewCommandOn, 0);
      chk("t5_addr_hold", o_DMA_ADDR, 32'h7000_0000);

      // Asynchronous reset mid-command, then normal operation
      push(32'h8000_0000, 6'd3);
      chk("t6_no_bypass", NewCommandOn, 0);
      chk("t6_count1", o_cmd_count, 1);
      step();
      chk("t6_active", NewCommandOn, 1);
      #2;
      HRESET = 1'b1;
      #1;
      chk("t6_rst_nco", NewCommandOn, 0);
      chk("t6_rst_addr", o_DMA_ADDR, 0);
      chk("t6_rst_done", o_done_cnt, 0);
      chk("t6_rst_count", o_cmd_count, 0);
      step();
      HRESET = 1'b0;
      push(32'h9000_0000, 6'd21);
      chk("t6_post_nco0", NewCommandOn, 0);
      chk("t6_post_count1", o_cmd_count, 1);
      step();
      chk("t6_post_nco1", NewCommandOn, 1);
      chk("t6_post_addr", o_DMA_ADDR, 32'h9000_0000);
      chk("t6_post_len", o_BUFFER_LENGTH, 21);
      chk("t6_post_count0", o_cmd_count, 0);
      done_pulse();
      chk("t6_post_done", o_done_cnt, 1);
      chk("t6_post_off", NewCommandOn, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
